fir_stream_sched: RTL and testbench

- Sequencer/arbiter in front of the 8-tap, 6-bit FIR core. Owns the core's three control inputs: x_n, s_axis_fir_tvalid, s_set_coeffs.
- Shares those inputs between two requesters: a coefficient-load requester (16-bit packed tap vector) and a sample stream (valid/ready).
- Guarantees mutually exclusive tvalid/set_coeffs and correct one-cycle data skew to the core.
- Captures the core's y_n into a qualified output stream.

---
 rtl/fir_stream_sched_if.sv | 26 ++
 rtl/fir_stream_sched.sv | 87 ++++++++
 tb/tb_fir_stream_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fir_stream_sched_if.sv
// fir_stream_sched_if: requester, sample-stream, FIR-core and output signals of the scheduler
interface fir_stream_sched_if;
    logic        cfg_req;
    logic [15:0] cfg_coeffs;
    logic        cfg_ack;
    logic        cfg_busy;
    logic        smp_valid;
    logic [5:0]  smp_data;
    logic        smp_ready;
    logic [5:0]  fir_x;
    logic        fir_tvalid;
    logic        fir_set;
    logic [7:0]  fir_y;
    logic        out_valid;
    logic [7:0]  out_data;

    modport slave (
        input  cfg_req, cfg_coeffs, smp_valid, smp_data, fir_y,
        output cfg_ack, cfg_busy, smp_ready, fir_x, fir_tvalid, fir_set, out_valid, out_data
    );

    modport master (
        output cfg_req, cfg_coeffs, smp_valid, smp_data, fir_y,
        input  cfg_ack, cfg_busy, smp_ready, fir_x, fir_tvalid, fir_set, out_valid, out_data
    );
endinterface

// File: rtl/fir_stream_sched.sv
// fir_stream_sched: shares the FIR core control inputs between coefficient loads and a sample stream
module fir_stream_sched #(
    parameter int MAX_DEFER = 8,
    parameter int CNT_W     = 8
) (
    input logic               clk,
    input logic               reset,
    fir_stream_sched_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_CFG, S_TAIL} state_t;

    state_t           state_q, state_n;
    logic [1:0]       ph_q, ph_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [15:0]      coef_q;
    logic [5:0]       word;
    logic             rdy_q, v1_q, at_max, go_cfg, ld;

    // rdy_q is low for one cycle after reset and throughout a load, so nothing is evaluated then
    assign at_max         = cnt_q == CNT_W'(MAX_DEFER);
    assign go_cfg         = rdy_q & bus.cfg_req & (~bus.smp_valid | at_max);
    assign bus.smp_ready  = rdy_q & ~(bus.cfg_req & bus.smp_valid & at_max);
    assign bus.fir_tvalid = bus.smp_valid & bus.smp_ready;
    assign word = ph_q == 2'd0 ? {coef_q[13:12], coef_q[15:14], 2'b00} :
                  ph_q == 2'd1 ? {coef_q[7:6], coef_q[9:8], coef_q[11:10]} :
                                 {coef_q[1:0], coef_q[3:2], coef_q[5:4]};

    always_comb begin
        state_n = state_q;
        ph_n    = ph_q;
        cnt_n   = cnt_q;
        ld      = 1'b0;
        case (state_q)
            S_IDLE, S_STREAM: begin
                if (go_cfg) begin
                    state_n = S_CFG;
                    ph_n    = 2'd0;
                    cnt_n   = '0;
                    ld      = 1'b1;
                end else if (rdy_q) begin
                    state_n = bus.fir_tvalid ? S_STREAM : S_IDLE;
                    cnt_n   = (bus.cfg_req & bus.smp_valid) ? cnt_q + CNT_W'(1) : '0;
                end
            end
            S_CFG: begin
                ph_n    = ph_q + 2'd1;
                state_n = ph_q == 2'd2 ? S_TAIL : S_CFG;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ph_q          <= '0;
            cnt_q         <= '0;
            coef_q        <= '0;
            rdy_q         <= 1'b0;
            v1_q          <= 1'b0;
            bus.cfg_ack   <= 1'b0;
            bus.cfg_busy  <= 1'b0;
            bus.fir_set   <= 1'b0;
            bus.fir_x     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            state_q       <= state_n;
            ph_q          <= ph_n;
            cnt_q         <= cnt_n;
            rdy_q         <= state_n == S_IDLE || state_n == S_STREAM;
            bus.cfg_ack   <= ld;
            bus.cfg_busy  <= state_n == S_CFG || state_n == S_TAIL;
            bus.fir_set   <= state_n == S_CFG;
            v1_q          <= bus.fir_tvalid;
            bus.out_valid <= v1_q;
            if (ld)
                coef_q <= bus.cfg_coeffs;
            if (bus.fir_tvalid)
                bus.fir_x <= bus.smp_data;
            else if (bus.fir_set)
                bus.fir_x <= word;
            if (v1_q)
                bus.out_data <= bus.fir_y;
        end
    end
endmodule

// File: tb/tb_fir_stream_sched.sv
// tb_fir_stream_sched: directed checks of the scheduler against a behavioural 8-tap FIR core
module tb_fir_stream_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic        tv_d = 1'b0;
    logic        st_d = 1'b0;
    logic [1:0]  lp = '0;
    logic [15:0] taps = 16'h1111;
    logic [47:0] hist = '0;
    logic        acked;
    logic [7:0]  ex [4] = '{8'd1, 8'd3, 8'd6, 8'd10};

    fir_stream_sched_if bus();

    fir_stream_sched #(.MAX_DEFER(4), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fy(input logic [47:0] h, input logic [15:0] t);
        int s = 0;
        for (int k = 0; k < 8; k++)
            s += $signed(t[2*k +: 2]) * $signed(h[6*k +: 6]);
        return 8'(s);
    endfunction

    // core model: control sampled at the rising edge, data word read at the next falling edge
    always @(posedge clk) begin
        tv_d <= reset ? 1'b0 : bus.fir_tvalid;
        st_d <= reset ? 1'b0 : bus.fir_set;
    end

    always @(negedge clk) begin
        if (reset) begin
            taps      <= 16'h1111;
            hist      <= '0;
            lp        <= '0;
            bus.fir_y <= '0;
        end else if (tv_d) begin
            hist      <= {hist[41:0], bus.fir_x};
            bus.fir_y <= fy({hist[41:0], bus.fir_x}, taps);
        end else begin
            hist <= '0;
            if (st_d) begin
                lp <= lp == 2'd2 ? 2'd0 : lp + 2'd1;
                case (lp)
                    2'd0:    taps[15:12] <= {bus.fir_x[3:2], bus.fir_x[5:4]};
                    2'd1:    taps[11:6]  <= {bus.fir_x[1:0], bus.fir_x[3:2], bus.fir_x[5:4]};
                    default: taps[5:0]   <= {bus.fir_x[1:0], bus.fir_x[3:2], bus.fir_x[5:4]};
                endcase
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.cfg_req    = 1'b0;
        bus.cfg_coeffs = '0;
        bus.smp_valid  = 1'b0;
        bus.smp_data   = '0;
        repeat (3) cyc();
        chk("rst_ctl", 16'({bus.cfg_ack, bus.cfg_busy, bus.smp_ready, bus.fir_tvalid, bus.fir_set, bus.out_valid}), 16'h0);
        chk("rst_x", 16'(bus.fir_x), 16'h0);
        chk("rst_out", 16'(bus.out_data), 16'h0);
        reset = 1'b0;
        cyc();
        chk("idle_rdy", 16'(bus.smp_ready), 16'h1);
        chk("idle_ctl", 16'({bus.cfg_ack, bus.cfg_busy, bus.fir_tvalid, bus.fir_set, bus.out_valid}), 16'h0);

        cyc();
        bus.cfg_req    = 1'b1;
        bus.cfg_coeffs = 16'hE4E4;
        cyc();
        chk("ld_ack", 16'(bus.cfg_ack), 16'h1);
        chk("ld_set1", 16'(bus.fir_set), 16'h1);
        chk("ld_busy1", 16'(bus.cfg_busy), 16'h1);
        chk("ld_rdy1", 16'(bus.smp_ready), 16'h0);
        bus.cfg_req = 1'b0;
        cyc();
        chk("ld_ack2", 16'(bus.cfg_ack), 16'h0);
        chk("ld_set2", 16'(bus.fir_set), 16'h1);
        chk("ld_w0", 16'(bus.fir_x), 16'h2C);
        cyc();
        chk("ld_set3", 16'(bus.fir_set), 16'h1);
        chk("ld_w1", 16'(bus.fir_x), 16'h31);
        cyc();
        chk("ld_set4", 16'(bus.fir_set), 16'h0);
        chk("ld_busy4", 16'(bus.cfg_busy), 16'h1);
        chk("ld_w2", 16'(bus.fir_x), 16'h06);
        cyc();
        chk("ld_busy5", 16'(bus.cfg_busy), 16'h0);
        chk("ld_rdy5", 16'(bus.smp_ready), 16'h1);
        chk("ld_taps", taps, 16'hE4E4);

        cyc();
        bus.cfg_req    = 1'b1;
        bus.cfg_coeffs = 16'h5555;
        cyc();
        chk("ld1_ack", 16'(bus.cfg_ack), 16'h1);
        bus.cfg_req = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i == 0)
                chk("ld1_taps", taps, 16'h5555);
            bus.smp_valid = i < 4;
            bus.smp_data  = 6'(i + 1);
            #1;
            chk("st_tvalid", 16'(bus.fir_tvalid), 16'(i < 4));
            chk("st_ovalid", 16'(bus.out_valid), 16'(i >= 2 && i < 6));
            if (i >= 2 && i < 6)
                chk("st_odata", 16'(bus.out_data), 16'(ex[i-2]));
        end
        bus.smp_valid = 1'b0;

        acked = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (bus.cfg_ack)
                acked = 1'b1;
            bus.smp_valid = 1'b1;
            bus.smp_data  = 6'(i);
            bus.cfg_req   = i >= 10 && !acked;
            #1;
            chk("pre_rdy", 16'(bus.smp_ready), 16'(!(i >= 14 && i <= 18)));
            chk("pre_ack", 16'(bus.cfg_ack), 16'(i == 15));
            chk("pre_excl", 16'(bus.fir_tvalid & bus.fir_set), 16'h0);
        end

        cyc();
        bus.smp_valid = 1'b0;
        bus.cfg_req   = 1'b1;
        #1;
        chk("pause_cnt", 16'(dut.cnt_q), 16'h0);
        chk("pause_rdy", 16'(bus.smp_ready), 16'h1);
        cyc();
        chk("pause_ack", 16'(bus.cfg_ack), 16'h1);
        chk("pause_cnt2", 16'(dut.cnt_q), 16'h0);
        bus.cfg_req = 1'b0;
        repeat (4) cyc();

        cyc();
        bus.cfg_req = 1'b1;
        cyc();
        chk("rl_ack", 16'(bus.cfg_ack), 16'h1);
        cyc();
        chk("rl_set", 16'(bus.fir_set), 16'h1);
        reset = 1'b1;
        cyc();
        chk("rl_ctl", 16'({bus.cfg_ack, bus.cfg_busy, bus.smp_ready, bus.fir_tvalid, bus.fir_set, bus.out_valid}), 16'h0);
        chk("rl_x", 16'(bus.fir_x), 16'h0);
        chk("rl_taps", taps, 16'h1111);
        reset = 1'b0;
        cyc();
        chk("rl_ack1", 16'(bus.cfg_ack), 16'h0);
        chk("rl_rdy1", 16'(bus.smp_ready), 16'h1);
        cyc();
        chk("rl_ack2", 16'(bus.cfg_ack), 16'h1);
        bus.cfg_req = 1'b0;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
